// File: rtl/pc_seq_ctrl.sv
// Population-count sequencer built around one shared 7:3 parallel counter.
//
// A DATA_W-bit word is latched on an accepted start and presented to the
// external counter one 7-bit chunk per cycle, least-significant chunk first.
// The 3-bit partial counts are accumulated, and the total is published on
// count_o together with a one-cycle done_o pulse.
//
// Ports:
//   clk_i       system clock, all state updates on the rising edge
//   rst_ni      synchronous active-low reset
//   start_i     request, accepted only while busy_o is low
//   din_i       word to count, sampled on the accepting edge only
//   busy_o      high while a request is in progress (run or done phase)
//   done_o      one-cycle pulse, count_o was just updated
//   count_o     popcount of the last accepted word, held between requests
//   pc_d_o      chunk driven to the shared counter, zero outside the run phase
//   pc_count_i  combinational result of the shared counter for pc_d_o
module pc_seq_ctrl #(
    parameter int unsigned DATA_W = 28,
    parameter int unsigned NCHUNK = DATA_W / 7,
    parameter int unsigned CW     = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] din_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CW-1:0]     count_o,
    output logic [6:0]        pc_d_o,
    input  logic [2:0]        pc_count_i
);

    if ((DATA_W % 7) != 0 || DATA_W == 0) begin : g_bad_width
        $error("pc_seq_ctrl: DATA_W must be a non-zero multiple of 7");
    end

    localparam int unsigned IdxW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     acc_q, acc_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        pc_d_o  = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    shreg_d = din_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy_o  = 1'b1;
                pc_d_o  = shreg_q[6:0];
                // Accumulator cannot overflow: its maximum is DATA_W.
                acc_d   = acc_q + CW'(pc_count_i);
                shreg_d = shreg_q >> 7;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    // Publish including the final chunk added on this edge.
                    count_d = acc_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            shreg_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Sequencer that time-shares one combinational 7:3 parallel counter (pc_fa_7_3) to compute the population count of a DATA_W-bit word over several clock cycles.
- Latches the word and feeds it to the counter one 7-bit chunk per cycle, LSB chunk first.
- Accumulates the counter's 3-bit results and reports the total with a start/busy/done handshake.
- Sits between the board I/O (switch/register source) and the shared counter instance in the FPGA top level.

Parameters:
- DATA_W, 28, input word width; must be a multiple of 7, and any other value is an elaboration error.
- NCHUNK, DATA_W/7, derived; number of counter passes.
- CW, $clog2(DATA_W+1), derived; result width (5 for the default).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request; accepted only when busy=0
- din  input  DATA_W  word to count; sampled only on the accepting edge
- busy  output  1  high while a request is in progress (RUN or DONE)
- done  output  1  one-cycle pulse; count is valid and newly updated
- count  output  CW  popcount of last accepted din; holds between requests
- pc_d  output  7  chunk driven to the shared counter's d input
- pc_count  input  3  counter result for pc_d (combinational, same cycle)

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, count=0, pc_d=0, accumulator=0, chunk index=0. This applies from any state; a request in flight is discarded and done is not generated.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, pc_d=0.
  - On an edge with start=1: shift register <= din, acc <= 0, idx <= 0, next state RUN.
  - On an edge with start=0: remain in IDLE.
- RUN:
  - busy=1. pc_d = shreg[6:0] combinationally.
  - Each edge: acc <= acc + pc_count (zero-extended to CW, no overflow possible), shreg <= shreg >> 7, idx <= idx+1.
  - On the edge where idx==NCHUNK-1: next state DONE.
- DONE:
  - Entry edge loads count <= final acc. count is a register, so acc gets its final add on the last RUN edge.
  - During DONE: done=1, busy=1, pc_d=0. Next edge returns to IDLE; done returns to 0.
- Latency: for a start accepted at edge E0, RUN occupies cycles E0..E0+NCHUNK-1. done=1 and the new count are visible in the cycle after edge E0+NCHUNK.
  - Default: done is high in the cycle following the 4th edge after acceptance.
  - Minimum request period is NCHUNK+2 cycles (accept, NCHUNK runs, done, idle edge).
- Handshake and boundary rules:
  - start while busy=1 (RUN or DONE) is ignored and not queued.
  - start held continuously high is re-accepted on the first IDLE edge, giving back-to-back requests with exactly one IDLE cycle between done pulses and the next RUN.
  - din changes after acceptance do not affect the result.
  - count changes only on DONE entry or reset. It is stable at all other times, including during RUN.
  - pc_d is 0 whenever not in RUN, which keeps the shared counter quiescent.
  - No wrap-around: the accumulator max is DATA_W, which fits in CW.

Test Plan:
1. Reset then din=28'h0, start pulse -> busy high for 5 cycles, one done pulse, count=0; pc_d=0 outside RUN.
2. din=28'hFFFFFFF, start pulse -> pc_d=7'h7F on each of the 4 RUN cycles, done pulse NCHUNK+1 cycles after acceptance, count=28 (5'b11100).
3. din=28'h5555555 -> pc_d sequence 55,2A,55,2A (hex, LSB chunk first), count=14. Then din=28'h0000001 -> count=1, and count holds 14 until that done.
4. Start pulses during RUN and during DONE, with din changed mid-run to 28'hFFFFFFF after accepting 28'h000007F -> only one done pulse, count=7, no second request.
5. start held high with din=28'h00000FF -> repeated done pulses every 6 cycles, count=8 each time.
6. rst_n=0 for one edge in the 2nd RUN cycle of din=28'hFFFFFFF -> next cycle IDLE, busy=0, done never asserted, count=0. A following request for 28'h0000003 gives count=2.
